// File: rtl/lbus_if_stream.sv
// LBUS slave: loads an a/b operand bank, streams it to the arithmetic core over
// valid/ready and captures the result. Optional WAIT watchdog: LBUS_IF_STREAM_TIMEOUT_EN.
module lbus_if_stream #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned OP_W    = 24,
    parameter int unsigned A_DEPTH = 6,
    parameter int unsigned DOUT_W  = 128,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] lbus_a,
    input  logic [DATA_W-1:0] lbus_di,
    input  logic              lbus_wr,
    input  logic              lbus_rd,
    output logic [DATA_W-1:0] lbus_do,
    output logic [OP_W-1:0]   a,
    output logic [OP_W-1:0]   b,
    output logic              op_vld,
    input  logic              op_rdy,
    output logic              op_last,
    output logic              blk_en,
    input  logic [DOUT_W-1:0] blk_dout,
    input  logic              blk_dvld,
    output logic              done
);

    localparam int unsigned IDX_W = (A_DEPTH > 1) ? $clog2(A_DEPTH) : 1;
    localparam int unsigned HI_W  = OP_W - DATA_W;
    localparam int unsigned NW    = DOUT_W / DATA_W;
    localparam int unsigned RW    = (NW > 1) ? $clog2(NW) : 1;

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(A_DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_STAT = ADDR_W'(32'h0000);
    localparam logic [ADDR_W-1:0] ADDR_CTRL = ADDR_W'(32'h0002);
    localparam logic [ADDR_W-1:0] A_BASE    = ADDR_W'(32'h0100);
    localparam logic [ADDR_W-1:0] A_END     = ADDR_W'(32'h0100 + 2 * A_DEPTH);
    localparam logic [ADDR_W-1:0] B_LO      = ADDR_W'(32'h0110);
    localparam logic [ADDR_W-1:0] B_HI      = ADDR_W'(32'h0111);
    localparam logic [ADDR_W-1:0] R_BASE    = ADDR_W'(32'h0180);
    localparam logic [ADDR_W-1:0] R_END     = ADDR_W'(32'h0180 + NW);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    // Decoding relies on the a-bank fitting in 0x0100..0x010F and results in 0x0180..0x01BF.
    if (OP_W <= DATA_W || OP_W > 2 * DATA_W || A_DEPTH < 1 || A_DEPTH > 8 ||
        (DOUT_W % DATA_W) != 0 || NW > 64 || TIMEOUT < 1) begin : g_param_err
        $error("lbus_if_stream: illegal parameter set");
    end

    logic [1:0]                    state_q, state_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [OP_W-1:0]               a_bank_q [A_DEPTH];
    logic [OP_W-1:0]               a_bank_d [A_DEPTH];
    logic [OP_W-1:0]               b_bank_q, b_bank_d;
    logic [NW-1:0][DATA_W-1:0]     result_q, result_d;
    logic                          done_q, done_d;
    logic                          ovr_q, ovr_d;
    logic                          tmo_q, tmo_d;
    logic                          wr_pend_q, wr_pend_d;
    logic [ADDR_W-1:0]             wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]             lbus_do_q, lbus_do_d;
    logic [OP_W-1:0]               a_q, a_d;
    logic [OP_W-1:0]               b_q, b_d;
    logic                          op_vld_q, op_vld_d;
    logic                          op_last_q, op_last_d;
    logic                          blk_en_q, blk_en_d;

`ifdef LBUS_IF_STREAM_TIMEOUT_EN
    localparam int unsigned       TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
    logic [TMO_W-1:0]             tmo_cnt_q, tmo_cnt_d;
`endif

    logic                          busy_c;
    logic                          w_is_a, w_is_op;
    logic [IDX_W-1:0]              w_idx;
    logic                          r_is_a, r_is_res;
    logic [IDX_W-1:0]              r_idx;
    logic [RW-1:0]                 r_k;
    logic [DATA_W-1:0]             rd_data_c;

    assign busy_c  = (state_q != ST_IDLE);
    assign w_is_a  = (wr_addr_q >= A_BASE) && (wr_addr_q < A_END);
    assign w_is_op = w_is_a || (wr_addr_q == B_LO) || (wr_addr_q == B_HI);
    assign w_idx   = wr_addr_q[IDX_W:1];
    assign r_is_a  = (lbus_a >= A_BASE) && (lbus_a < A_END);
    assign r_is_res = (lbus_a >= R_BASE) && (lbus_a < R_END);
    assign r_idx   = lbus_a[IDX_W:1];
    assign r_k     = lbus_a[RW-1:0];

    // Read mux; unmapped addresses (including CTRL) return 0.
    always_comb begin
        rd_data_c = '0;
        if (lbus_a == ADDR_STAT) begin
            rd_data_c = DATA_W'({tmo_q, ovr_q, done_q, busy_c});
        end else if (r_is_a) begin
            if (lbus_a[0]) rd_data_c = DATA_W'(a_bank_q[r_idx][OP_W-1:DATA_W]);
            else           rd_data_c = a_bank_q[r_idx][DATA_W-1:0];
        end else if (lbus_a == B_LO) begin
            rd_data_c = b_bank_q[DATA_W-1:0];
        end else if (lbus_a == B_HI) begin
            rd_data_c = DATA_W'(b_bank_q[OP_W-1:DATA_W]);
        end else if (r_is_res) begin
            rd_data_c = result_q[r_k];
        end
    end

    // Next-state: write capture/commit, operand streaming, result capture.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_bank_d  = a_bank_q;
        b_bank_d  = b_bank_q;
        result_d  = result_q;
        done_d    = done_q;
        ovr_d     = ovr_q;
        tmo_d     = tmo_q;
        wr_pend_d = 1'b0;
        wr_addr_d = wr_addr_q;
`ifdef LBUS_IF_STREAM_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif

        // A strobe seen on the commit edge belongs to the write already in flight.
        if (!wr_pend_q && lbus_wr) begin
            wr_pend_d = 1'b1;
            wr_addr_d = lbus_a;
        end

        case (state_q)
            ST_LOAD: begin
                if (op_vld_q && op_rdy) begin
                    if (idx_q == IDX_LAST) state_d = ST_WAIT;
                    else                   idx_d   = idx_q + IDX_W'(1);
                end
            end
            ST_WAIT: begin
                if (blk_dvld) begin
                    result_d = blk_dout;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end
`ifdef LBUS_IF_STREAM_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
`endif
            end
            default: ;
        endcase

        // Commit overrides the FSM so a soft clear always wins.
        if (wr_pend_q) begin
            if (wr_addr_q == ADDR_CTRL) begin
                if (lbus_di[1]) begin
                    state_d  = ST_IDLE;
                    idx_d    = '0;
                    done_d   = 1'b0;
                    ovr_d    = 1'b0;
                    tmo_d    = 1'b0;
                    result_d = '0;
`ifdef LBUS_IF_STREAM_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end else if (lbus_di[0] && !busy_c) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                    done_d  = 1'b0;
                    ovr_d   = 1'b0;
                    tmo_d   = 1'b0;
                end
            end else if (w_is_op) begin
                if (busy_c) begin
                    ovr_d = 1'b1;
                end else if (w_is_a) begin
                    if (wr_addr_q[0]) a_bank_d[w_idx][OP_W-1:DATA_W] = lbus_di[HI_W-1:0];
                    else              a_bank_d[w_idx][DATA_W-1:0]    = lbus_di;
                end else if (wr_addr_q == B_LO) begin
                    b_bank_d[DATA_W-1:0] = lbus_di;
                end else begin
                    b_bank_d[OP_W-1:DATA_W] = lbus_di[HI_W-1:0];
                end
            end
        end

        // Outputs are registered from the next state so they line up with it.
        op_vld_d  = (state_d == ST_LOAD);
        op_last_d = op_vld_d && (idx_d == IDX_LAST);
        a_d       = op_vld_d ? a_bank_q[idx_d] : '0;
        b_d       = (state_d != ST_IDLE) ? b_bank_q : '0;
        blk_en_d  = (state_d != ST_IDLE);
        lbus_do_d = lbus_rd ? lbus_do_q : rd_data_c;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            for (int i = 0; i < int'(A_DEPTH); i++) a_bank_q[i] <= '0;
            b_bank_q  <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
            tmo_q     <= 1'b0;
            wr_pend_q <= 1'b0;
            wr_addr_q <= '0;
            lbus_do_q <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_vld_q  <= 1'b0;
            op_last_q <= 1'b0;
            blk_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            a_bank_q  <= a_bank_d;
            b_bank_q  <= b_bank_d;
            result_q  <= result_d;
            done_q    <= done_d;
            ovr_q     <= ovr_d;
            tmo_q     <= tmo_d;
            wr_pend_q <= wr_pend_d;
            wr_addr_q <= wr_addr_d;
            lbus_do_q <= lbus_do_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_vld_q  <= op_vld_d;
            op_last_q <= op_last_d;
            blk_en_q  <= blk_en_d;
        end
    end

`ifdef LBUS_IF_STREAM_TIMEOUT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) tmo_cnt_q <= '0;
        else       tmo_cnt_q <= tmo_cnt_d;
    end
`endif

    assign lbus_do = lbus_do_q;
    assign a       = a_q;
    assign b       = b_q;
    assign op_vld  = op_vld_q;
    assign op_last = op_last_q;
    assign blk_en  = blk_en_q;
    assign done    = done_q;

endmodule

// File: tb/tb_lbus_if_stream.sv
// Randomized bench for lbus_if_stream against a register-map level model.
`timescale 1ns/1ps
module tb_lbus_if_stream;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned OP_W    = 24;
    localparam int unsigned A_DEPTH = 6;
    localparam int unsigned DOUT_W  = 128;
`ifdef LBUS_IF_STREAM_TIMEOUT_EN
    localparam int unsigned TMO = 16;
`else
    localparam int unsigned TMO = 1024;
`endif
    localparam logic [15:0] CTRL = 16'h0002;

    logic              clk, rstn;
    logic [ADDR_W-1:0] lbus_a;
    logic [DATA_W-1:0] lbus_di, lbus_do;
    logic              lbus_wr, lbus_rd;
    logic [OP_W-1:0]   a, b;
    logic              op_vld, op_rdy, op_last, blk_en, blk_dvld, done;
    logic [DOUT_W-1:0] blk_dout;

    lbus_if_stream #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .OP_W(OP_W),
        .A_DEPTH(A_DEPTH), .DOUT_W(DOUT_W), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rstn(rstn), .lbus_a(lbus_a), .lbus_di(lbus_di),
        .lbus_wr(lbus_wr), .lbus_rd(lbus_rd), .lbus_do(lbus_do),
        .a(a), .b(b), .op_vld(op_vld), .op_rdy(op_rdy), .op_last(op_last),
        .blk_en(blk_en), .blk_dout(blk_dout), .blk_dvld(blk_dvld), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: register map contents and status flags.
    logic [OP_W-1:0]   m_a [A_DEPTH];
    logic [OP_W-1:0]   m_b;
    logic [DOUT_W-1:0] m_res;
    bit m_busy, m_done, m_ovr, m_tmo;

    function automatic void model_reset();
        for (int i = 0; i < int'(A_DEPTH); i++) m_a[i] = '0;
        m_b = '0; m_res = '0;
        m_busy = 0; m_done = 0; m_ovr = 0; m_tmo = 0;
    endfunction

    function automatic void model_write(input logic [15:0] addr, input logic [15:0] data);
        int off;
        off = int'(addr) - 'h100;
        if (addr == CTRL) begin
            if (data[1]) begin
                m_busy = 0; m_done = 0; m_ovr = 0; m_tmo = 0; m_res = '0;
            end else if (data[0] && !m_busy) begin
                m_busy = 1; m_done = 0; m_ovr = 0; m_tmo = 0;
            end
        end else if ((off >= 0 && off < 2 * int'(A_DEPTH)) || addr == 16'h0110 || addr == 16'h0111) begin
            if (m_busy) m_ovr = 1;
            else if (addr == 16'h0110) m_b = {m_b[23:16], data};
            else if (addr == 16'h0111) m_b = {data[7:0], m_b[15:0]};
            else if (off % 2 == 0)     m_a[off / 2] = {m_a[off / 2][23:16], data};
            else                       m_a[off / 2] = {data[7:0], m_a[off / 2][15:0]};
        end
    endfunction

    function automatic logic [15:0] model_read(input logic [15:0] addr);
        int off;
        off = int'(addr) - 'h100;
        if (addr == 16'h0000)                   return {12'd0, m_tmo, m_ovr, m_done, m_busy};
        if (off >= 0 && off < 2 * int'(A_DEPTH))
            return (off % 2 == 0) ? m_a[off / 2][15:0] : {8'd0, m_a[off / 2][23:16]};
        if (addr == 16'h0110)                   return m_b[15:0];
        if (addr == 16'h0111)                   return {8'd0, m_b[23:16]};
        if (addr >= 16'h0180 && addr < 16'h0188) return 16'(m_res >> (16 * (int'(addr) - 'h180)));
        return 16'h0000;
    endfunction

    task automatic lb_write(input logic [15:0] addr, input logic [15:0] data);
        @(negedge clk); lbus_a = addr; lbus_wr = 1'b1;
        @(negedge clk); lbus_wr = 1'b0; lbus_di = data;
        @(negedge clk);
        model_write(addr, data);
    endtask

    task automatic lb_read_chk(input logic [15:0] addr, input string tag);
        @(negedge clk); lbus_a = addr; lbus_rd = 1'b0;
        @(negedge clk); lbus_rd = 1'b1;
        chk(tag, lbus_do, model_read(addr));
    endtask

    // op_rdy driver: 0 always, 1 pattern 1,0,0, 2 random, 3 held low.
    int rdy_mode = 3;
    int rdy_pc   = 0;
    initial begin
        op_rdy = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       op_rdy = 1'b1;
                1:       op_rdy = (rdy_pc % 3 == 0);
                2:       op_rdy = 1'($urandom_range(0, 1));
                default: op_rdy = 1'b0;
            endcase
            rdy_pc++;
        end
    end

    // Beat monitor: records transfers and checks hold-during-stall.
    logic [OP_W-1:0] q_a[$];
    logic [OP_W-1:0] q_b[$];
    logic            q_last[$];
    bit              mon_en = 0;
    initial begin
        bit stall_q;
        logic [OP_W-1:0] stall_a;
        stall_q = 0; stall_a = '0;
        forever begin
            @(negedge clk);
            if (mon_en && rstn) begin
                if (stall_q) begin
                    chk("stall_hold_a", a, stall_a);
                    chk("stall_hold_vld", op_vld, 1'b1);
                end
                if (op_vld) chk("blk_en_in_load", blk_en, 1'b1);
                if (op_vld && op_rdy) begin
                    q_a.push_back(a); q_b.push_back(b); q_last.push_back(op_last);
                end
                stall_q = op_vld && !op_rdy;
                stall_a = a;
            end else begin
                stall_q = 0;
            end
        end
    end

    task automatic collect(input string tag);
        int n;
        n = 0;
        while (op_vld && n < 300) begin @(negedge clk); n++; end
        chk({tag, "_stream_end"}, op_vld, 1'b0);
        chk({tag, "_nbeats"}, q_a.size(), A_DEPTH);
        for (int i = 0; i < int'(A_DEPTH) && i < q_a.size(); i++) begin
            chk($sformatf("%s_a%0d", tag, i), q_a[i], m_a[i]);
            chk($sformatf("%s_b%0d", tag, i), q_b[i], m_b);
            chk($sformatf("%s_last%0d", tag, i), q_last[i], (i == int'(A_DEPTH) - 1));
        end
        chk({tag, "_blk_en_wait"}, blk_en, 1'b1);
    endtask

    task automatic start_run(input int mode);
        q_a.delete(); q_b.delete(); q_last.delete();
        rdy_mode = mode;
        lb_write(CTRL, 16'h0001);
    endtask

    task automatic finish_run(input logic [DOUT_W-1:0] dout, input string tag);
        @(negedge clk); blk_dout = dout; blk_dvld = 1'b1;
        @(negedge clk); blk_dvld = 1'b0; blk_dout = {4{$urandom}};
        m_res = dout; m_done = 1; m_busy = 0;
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_blk_en_idle"}, blk_en, 1'b0);
    endtask

    initial begin
        int n;
        logic [15:0] hold_v;
        rstn = 1'b0; lbus_a = '0; lbus_di = '0; lbus_wr = 1'b0; lbus_rd = 1'b1;
        blk_dout = '0; blk_dvld = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_lbus_do", lbus_do, 16'h0);
        chk("rst_op_vld", op_vld, 1'b0);
        chk("rst_blk_en", blk_en, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_a", a, 24'h0);
        chk("rst_b", b, 24'h0);
        chk("rst_op_last", op_last, 1'b0);
        rstn = 1'b1;
        mon_en = 1;
        lb_read_chk(16'h0000, "stat_reset");

        // Fixed operand set, always-ready streaming
        lb_write(16'h0100, 16'haaaa); lb_write(16'h0101, 16'h00bb);
        lb_write(16'h0102, 16'hcccc); lb_write(16'h0103, 16'h00dd);
        lb_write(16'h0104, 16'heeee); lb_write(16'h0105, 16'h00ff);
        lb_write(16'h0106, 16'h1111); lb_write(16'h0107, 16'h0022);
        lb_write(16'h0108, 16'h3333); lb_write(16'h0109, 16'h0044);
        lb_write(16'h010a, 16'h5555); lb_write(16'h010b, 16'hff66);
        lb_write(16'h0110, 16'h7777); lb_write(16'h0111, 16'h0088);
        lb_read_chk(16'h0100, "a0_lo");
        lb_read_chk(16'h010b, "a5_hi_trunc");
        lb_read_chk(16'h0111, "b_hi");
        lb_write(16'h010c, 16'hbeef);
        lb_read_chk(16'h010c, "a6_unmapped");
        lb_read_chk(16'h0002, "ctrl_reads0");
        start_run(0);
        collect("t1");
`ifndef LBUS_IF_STREAM_TIMEOUT_EN
        repeat (40) @(negedge clk);
        chk("wait_unbounded", blk_en, 1'b1);
        lb_read_chk(16'h0000, "stat_wait");
`endif
        finish_run(128'h0123456789abcdef_fedcba9876543210, "t3");
        for (int k = 0; k < 8; k++) lb_read_chk(16'h0180 + 16'(k), $sformatf("res%0d", k));
        lb_read_chk(16'h0188, "res_oob");
        lb_read_chk(16'h0000, "stat_done");
        hold_v = model_read(16'h0000);
        @(negedge clk); lbus_a = 16'h0100;
        repeat (2) @(negedge clk);
        chk("rd_hold", lbus_do, hold_v);

        // blk_dvld outside WAIT must be ignored
        @(negedge clk); blk_dout = {4{$urandom}}; blk_dvld = 1'b1;
        @(negedge clk); blk_dvld = 1'b0;
        lb_read_chk(16'h0180, "dvld_idle_ignored");

        start_run(1);
        collect("t2");
        finish_run({4{$urandom}}, "t2");

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < int'(A_DEPTH); i++) begin
                lb_write(16'h0100 + 16'(2 * i), 16'($urandom));
                lb_write(16'h0101 + 16'(2 * i), 16'($urandom));
            end
            lb_write(16'h0110, 16'($urandom));
            lb_write(16'h0111, 16'($urandom));
            start_run(2);
            collect($sformatf("rnd%0d", r));
            finish_run({4{$urandom}}, $sformatf("rnd%0d", r));
            lb_read_chk(16'h0180 + 16'($urandom_range(0, 7)), $sformatf("rnd%0d_res", r));
            lb_read_chk(16'h0100 + 16'($urandom_range(0, 13)), $sformatf("rnd%0d_op", r));
            lb_read_chk(16'h0000, $sformatf("rnd%0d_stat", r));
        end

        // Writes while busy: dropped, overrun flagged, restart ignored
        start_run(3);
        lb_write(16'h0100, 16'h1234);
        lb_write(CTRL, 16'h0001);
        lb_read_chk(16'h0000, "stat_ovr");
        rdy_mode = 0;
        collect("t4");
        finish_run({4{$urandom}}, "t4");
        lb_read_chk(16'h0100, "a0_kept");
        lb_read_chk(16'h0000, "stat_ovr_done");
        start_run(3);
        lb_read_chk(16'h0000, "stat_restart");

        // Soft clear mid-LOAD, then start+clear together
        mon_en = 0;
        lb_write(CTRL, 16'h0002);
        chk("sclr_op_vld", op_vld, 1'b0);
        chk("sclr_blk_en", blk_en, 1'b0);
        lb_read_chk(16'h0000, "sclr_stat");
        lb_read_chk(16'h0180, "sclr_res");
        lb_read_chk(16'h0102, "sclr_bank_kept");
        lb_write(CTRL, 16'h0003);
        chk("start_clr_no_run", op_vld, 1'b0);
        lb_read_chk(16'h0000, "start_clr_stat");
        mon_en = 1;

`ifdef LBUS_IF_STREAM_TIMEOUT_EN
        start_run(0);
        collect("tmo");
        n = 0;
        while (blk_en && n < int'(TMO) + 50) begin @(negedge clk); n++; end
        chk("tmo_cycles", n, TMO);
        m_busy = 0; m_tmo = 1;
        lb_read_chk(16'h0000, "tmo_stat");
        chk("tmo_done", done, 1'b0);
`endif

        // Asynchronous reset in the middle of LOAD
        start_run(3);
        lb_read_chk(16'h0000, "stat_busy");
        mon_en = 0;
        @(negedge clk); #2 rstn = 1'b0;
        #1;
        chk("arst_op_vld", op_vld, 1'b0);
        chk("arst_blk_en", blk_en, 1'b0);
        chk("arst_lbus_do", lbus_do, 16'h0);
        chk("arst_done", done, 1'b0);
        model_reset();
        @(negedge clk); rstn = 1'b1;
        mon_en = 1;
        lb_read_chk(16'h0000, "arst_stat");
        lb_read_chk(16'h0100, "arst_a0");
        lb_read_chk(16'h0110, "arst_b");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench watchdog expired");
    end

endmodule

// File: doc/lbus_if_stream.md
Name: lbus_if_stream

Overview:
Parametrised local-bus slave. The controller fills an operand bank of A_DEPTH a-operands plus one b-operand through the 16-bit LBUS, then writes "start". The block streams the operands to the arithmetic core with a valid/ready handshake, captures the core's DOUT_W-bit result, and exposes result and status for LBUS readback. It sits between the LBUS controller and the crypto core, replacing the fixed 24-bit/single-shot interface.

Parameters:
ADDR_W, 16, LBUS address width
DATA_W, 16, LBUS data width
OP_W, 24, operand width; legal range 17..2*DATA_W
A_DEPTH, 6, number of a-operands; legal range 1..8
DOUT_W, 128, result width; must be a multiple of DATA_W, at most 64*DATA_W
TIMEOUT, 1024, WAIT watchdog limit in cycles; used only with the optional feature

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous reset, active-low
lbus_a  in  ADDR_W  bus address
lbus_di  in  DATA_W  write data
lbus_wr  in  1  write strobe, active-high
lbus_rd  in  1  read strobe, active-low
lbus_do  out  DATA_W  read data, registered
a  out  OP_W  streamed a-operand
b  out  OP_W  b-operand, held for the whole run
op_vld  out  1  operand beat valid
op_rdy  in  1  core accepts beat
op_last  out  1  last beat marker
blk_en  out  1  core enable, high in LOAD and WAIT
blk_dout  in  DOUT_W  core result
blk_dvld  in  1  result valid pulse
done  out  1  level; mirrors status bit 1

Behaviour:
- Reset: every output, the FSM, status, the result register and the operand bank are 0. Reset takes effect immediately and asynchronously, including mid-run.
- Address map:
  - 0x0000: STAT (read)
  - 0x0002: CTRL (write); bit0 = start, bit1 = soft clear
  - 0x0100+2i: a[i] bits [15:0]
  - 0x0101+2i: a[i] bits [OP_W-1:16]; unused upper di bits are dropped
  - 0x0110 / 0x0111: b low / high halves
  - 0x0180+k: result word k; word 0 is the LSBs
- Write protocol:
  - Edge k samples lbus_wr=1: the block latches lbus_a.
  - Edge k+1: the block samples lbus_di and commits it to the latched address.
  - Back-to-back writes are spaced by at least 2 edges.
  - Unmapped addresses and a-indices >= A_DEPTH are ignored.
- Read protocol:
  - At each edge where lbus_rd=0, lbus_do <= mux(lbus_a).
  - Latency is 1 cycle. Unmapped addresses read 0.
  - While lbus_rd=1, lbus_do holds its value.
- STAT bits:
  - [0]: busy
  - [1]: done, sticky
  - [2]: overrun, sticky
  - [3]: timeout, sticky
  - others: 0
- FSM IDLE -> LOAD:
  - Transition on a start write while IDLE.
  - done, overrun and timeout clear.
  - Beat index i=0.
- FSM LOAD:
  - op_vld=1, a=a[i], b=b-operand, op_last=(i==A_DEPTH-1).
  - A beat transfers on an edge with op_vld & op_rdy; then i++.
  - Outputs stay stable while op_rdy=0.
  - Transfer of the last beat goes to WAIT and deasserts op_vld the next cycle.
- FSM WAIT:
  - On blk_dvld=1, the result register <= blk_dout and done=1.
  - Next state is IDLE.
  - blk_dvld in any other state is ignored.
- Busy handling:
  - busy = (state != IDLE).
  - Start while busy is ignored.
  - Operand writes while busy are dropped and set overrun. The operand bank is never modified mid-run.
- Soft clear (CTRL bit1):
  - Synchronously forces IDLE, clears status, the result register and op_vld.
  - The operand bank is retained.
  - If start and soft clear are written together, soft clear wins and no run starts.
- The operand bank persists between runs, so re-start reuses the prior operands.

Optional Feature:
LBUS_IF_STREAM_TIMEOUT_EN:
- Defined: a counter runs in WAIT. If TIMEOUT cycles elapse without blk_dvld, the block sets STAT[3], returns to IDLE and leaves done=0. blk_dvld on the same cycle as expiry wins: done=1, no timeout.
- Undefined: WAIT is unbounded, STAT[3] reads 0, and no counter logic is built.

Test Plan:
1. Write a0..a5 = 0xbbaaaa, 0xddcccc, 0xffeeee, 0x221111, 0x443333, 0x665555 and b=0x887777, then start with op_rdy=1 -> 6 consecutive beats in that order, b=0x887777, op_last only on beat 6, blk_en=1.
2. Same run with op_rdy toggling 1,0,0,1... -> a held constant while op_rdy=0; still exactly 6 transfers.
3. In WAIT, pulse blk_dvld with blk_dout=128'h0123456789abcdef_fedcba9876543210 -> reads of 0x0180..0x0187 return 3210, 7654, ba98, fedc, cdef, 89ab, 4567, 0123; STAT reads 0x0002; done=1.
4. Write a0=0x1234 and then start, both during LOAD -> a0 unchanged, no restart, STAT[2]=1. The next start clears STAT[2].
5. Assert rstn=0 mid-LOAD -> op_vld, blk_en, lbus_do and done are 0 immediately; after release, STAT reads 0 and a0 reads 0.
6. With LBUS_IF_STREAM_TIMEOUT_EN and TIMEOUT=16, never assert blk_dvld -> IDLE after 16 WAIT cycles, STAT=0x0008, done=0.
